// File: rtl/sq_sched_pkg.sv
// Shared types and sizes for the window squaring scheduler: FSM states,
// window geometry, lane width, index type and the issue tag carried alongside the multiplier.
package sq_sched_pkg;

  localparam int WIN_N  = 9;
  localparam int LANE_W = 8;
  localparam int WIN_W  = WIN_N * LANE_W;

  typedef logic [3:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(WIN_N - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } state_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } tag_t;

  // Lane k of a packed window, lane 0 in the most significant byte.
  function automatic logic [LANE_W-1:0] lane(input logic [WIN_W-1:0] v, input idx_t k);
    return v[WIN_W-1-LANE_W*int'(k) -: LANE_W];
  endfunction

endpackage

// File: rtl/sq_tag_pipe.sv
// Delay line that follows each operand through the external multiplier, so the
// returning result can be written to the slot of the coefficient that produced it.
module sq_tag_pipe
  import sq_sched_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [MUL_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < MUL_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[MUL_LAT-1];

endmodule

// File: rtl/window_square_sched.sv
// Squares the nine coefficients of a 3x3 window through an external shared multiplier.
// Optional feature macro SQ_SCHED_PERF_CNT_EN adds the perf_windows handshake counter.
module window_square_sched
  import sq_sched_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIN_W-1:0] in_c,
  input  logic [WIN_W-1:0] in_p,
  output logic [7:0]       mul_op,
  input  logic [7:0]       mul_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIN_W-1:0] out_c,
  output logic [WIN_W-1:0] out_p
`ifdef SQ_SCHED_PERF_CNT_EN
  ,
  output logic [15:0]      perf_windows
`endif
);

  state_t           state, next_state;
  idx_t             issue_idx;
  logic [WIN_W-1:0] cap_c, cap_p, res_q;
  tag_t             issue_tag, done_tag;
  logic             accept, done;

  assign accept = (state == IDLE) && in_valid;
  assign done   = (state == HOLD) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_c <= '0;
      cap_p <= '0;
    end else if (accept) begin
      cap_c <= in_c;
      cap_p <= in_p;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          issue_idx <= '0;
    else if (state == ISSUE && issue_idx != LAST_IDX) issue_idx <= idx_t'(issue_idx + 1'b1);
    else                                              issue_idx <= '0;
  end

  // Results come back in issue order, but the tag decides the slot so latency never matters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 res_q <= '0;
    else if (done_tag.valid) res_q[WIN_W-1-LANE_W*int'(done_tag.idx) -: LANE_W] <= mul_res;
  end

  always_comb begin
    next_state = state;
    in_ready   = (state == IDLE);
    out_valid  = (state == HOLD);
    mul_op     = '0;
    issue_tag  = '0;
    case (state)
      IDLE:  if (accept) next_state = ISSUE;
      ISSUE: begin
        mul_op        = lane(cap_c, issue_idx);
        issue_tag.valid = 1'b1;
        issue_tag.idx   = issue_idx;
        if (issue_idx == LAST_IDX) next_state = DRAIN;
      end
      DRAIN: if (done_tag.valid && done_tag.idx == LAST_IDX) next_state = HOLD;
      HOLD:  if (done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  sq_tag_pipe #(.MUL_LAT(MUL_LAT)) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (issue_tag),
    .tag_out(done_tag)
  );

  assign out_c = res_q;
  assign out_p = cap_p;

`ifdef SQ_SCHED_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       perf_windows <= '0;
    else if (done) perf_windows <= perf_windows + 16'd1;
  end
`endif

endmodule
